up_dn_counter_5b: RTL
=====================

// Module: up_dn_counter_5b
// PURPOSE
//  Saturating 5-bit up/down counter with parallel load; the sequential consumer of the
//  registered control lines produced by the combinational/flop stage upstream.
//  Converts level commands (Load/Down/Up) into a held count value plus bound flags.
//  Sits directly downstream of the control-generation stage; outputs feed display/compare logic.
// PARAMETERS
//  WIDTH    5        counter and load-value width in bits
//  MAX_VAL  31       upper saturation bound (must be <= 2**WIDTH-1)
// PORTS
//  CLK      in   1       rising-edge clock, single clock domain
//  RST      in   1       asynchronous, active-low reset
//  IN       in   WIDTH   parallel load value
//  Load     in   1       load IN into counter (highest priority)
//  Down     in   1       decrement request
//  Up       in   1       increment request
//  Counter  out  WIDTH   current count (registered)
//  High     out  1       Counter == MAX_VAL
//  Low      out  1       Counter == 0
//  Tc       out  1       registered 1-cycle pulse: a count step hit a bound this edge
// BEHAVIOUR
//  - Interface: one clock CLK; reset RST is asynchronous and active-low.
//  - RST=0 (any time, no clock needed): Counter=0, Tc=0; hence Low=1, High=0.
//  - RST deassertion: counting resumes on first rising CLK with RST=1.
//  - Commands sampled on rising CLK; result visible in Counter one cycle later.
//  - Priority per edge: Load > Down > Up > hold.
//     Load=1          : Counter <= IN (IN > MAX_VAL clamps to MAX_VAL)
//     Down=1, Low=0   : Counter <= Counter-1
//     Down=1, Low=1   : hold at 0 (no wrap), Up ignored
//     Up=1,   High=0  : Counter <= Counter+1
//     Up=1,   High=1  : hold at MAX_VAL (no wrap)
//     none            : hold
//  - Up and Down both 1 without Load: Down wins.
//  - High/Low: combinational decode of registered Counter only (no input paths).
//  - Tc <= 1 for one cycle when a Down step lands on 0 or an Up step lands on MAX_VAL;
//    Load never asserts Tc; a blocked step at a bound does not re-assert Tc.
//  - All arithmetic in WIDTH bits; no overflow possible since bounds are checked first.
//  - State: Counter register (WIDTH) + Tc flop; no other storage.
//  - Exactly one clocked always block for all flops, non-blocking assignments only;
//    next-state logic in a single combinational block with blocking assignments.
// STRUCTURE
//  - Shared package up_dn_pkg: CNT_W=5, CNT_MAX=31, 2-bit command enum
//    CMD_HOLD=2'b00, CMD_UP=2'b01, CMD_DN=2'b10, CMD_LOAD=2'b11.
//  - One sub-module: up_dn_cmd_dec (Load/Down/Up -> command enum, priority encoder,
//    purely combinational). Counter datapath and flags stay in the top.
// TESTING
//  1. RST=0 mid-count at Counter=17 -> Counter=0, Low=1, High=0, Tc=0 immediately, no CLK edge.
//  2. Load=1 IN=10, then Up=1 x3 cycles -> Counter 10,11,12,13; Tc=0 throughout.
//  3. Load IN=29, Up=1 x4 -> 30,31,31,31; High=1 from 31; Tc=1 only the cycle after 30->31.
//  4. Load IN=2, Down=1 x4 -> 1,0,0,0; Low=1 from 0; Tc single pulse; no wrap to 31.
//  5. Counter=5, Load=1 IN=20 Up=1 Down=1 -> 20; next Up=1 Down=1 -> 19 (Down beats Up).
//  6. Load with IN > MAX_VAL (build MAX_VAL=20, IN=25) -> Counter=20, High=1, Tc=0.

Source files
------------

// File: rtl/up_dn_pkg.sv
// Shared widths, bounds and the command encoding for the saturating up/down counter.
// Constants only; no logic.
package up_dn_pkg;

  localparam int CNT_W   = 5;
  localparam int CNT_MAX = 31;

  typedef enum logic [1:0] {
    CMD_HOLD = 2'b00,
    CMD_UP   = 2'b01,
    CMD_DN   = 2'b10,
    CMD_LOAD = 2'b11
  } cmd_e;

endpackage

// File: rtl/up_dn_cmd_dec.sv
// Priority encoder folding Load/Down/Up levels into one command (Load > Down > Up > hold).
// Purely combinational, zero latency; no flow control.
module up_dn_cmd_dec
  import up_dn_pkg::*;
(
  input  logic load,
  input  logic down,
  input  logic up,
  output cmd_e cmd
);

  always_comb begin
    cmd = CMD_HOLD;
    if (load)      cmd = CMD_LOAD;
    else if (down) cmd = CMD_DN;
    else if (up)   cmd = CMD_UP;
  end

endmodule

// File: rtl/up_dn_counter_5b.sv
// Saturating up/down counter with clamped parallel load and a registered bound-hit pulse.
// Commands take effect one CLK later; never stalls, commands are sampled every edge.
module up_dn_counter_5b
  import up_dn_pkg::*;
#(
  parameter int WIDTH   = CNT_W,
  parameter int MAX_VAL = CNT_MAX
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN,
  input  logic             Load,
  input  logic             Down,
  input  logic             Up,
  output logic [WIDTH-1:0] Counter,
  output logic             High,
  output logic             Low,
  output logic             Tc
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  cmd_e             cmd;
  logic [WIDTH-1:0] cnt_nxt;
  logic             tc_nxt;

  up_dn_cmd_dec u_cmd_dec (
    .load (Load),
    .down (Down),
    .up   (Up),
    .cmd  (cmd)
  );

  assign High = (Counter == MAX_C);
  assign Low  = (Counter == '0);

  // Bounds are checked before stepping, so the arithmetic can never wrap.
  always_comb begin
    cnt_nxt = Counter;
    tc_nxt  = 1'b0;
    case (cmd)
      CMD_LOAD: cnt_nxt = (IN > MAX_C) ? MAX_C : IN;
      CMD_DN: begin
        if (!Low) begin
          cnt_nxt = Counter - ONE;
          tc_nxt  = (Counter == ONE);
        end
      end
      CMD_UP: begin
        if (!High) begin
          cnt_nxt = Counter + ONE;
          tc_nxt  = (Counter == MAX_C - ONE);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Counter <= '0;
      Tc      <= 1'b0;
    end else begin
      Counter <= cnt_nxt;
      Tc      <= tc_nxt;
    end
  end

endmodule
